// File: rtl/mem_port_arbiter_if.sv
// Shared-memory arbiter bus: core port (c_*), loader port (l_*), memory side (m_*) and grant owner.
// slave = arbiter side, master = requesters plus memory macro.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_adr;
  logic [DW-1:0] c_wd;
  logic [DW-1:0] c_rd;
  logic          c_ack;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_adr;
  logic [DW-1:0] l_wd;
  logic [DW-1:0] l_rd;
  logic          l_ack;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd;

  logic          owner;

  modport slave (
    input  c_req, c_we, c_adr, c_wd,
    output c_rd, c_ack,
    input  l_req, l_we, l_adr, l_wd,
    output l_rd, l_ack,
    output m_en, m_we, m_adr, m_wd,
    input  m_rd,
    output owner
  );

  modport master (
    output c_req, c_we, c_adr, c_wd,
    input  c_rd, c_ack,
    output l_req, l_we, l_adr, l_wd,
    input  l_rd, l_ack,
    input  m_en, m_we, m_adr, m_wd,
    output m_rd,
    input  owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Core/loader arbiter for one fixed-latency memory; round-robin, or core-priority with ARB_CORE_PRIO_EN.
// Latency: ack MEM_LAT+1 cycles after the grant edge; one access per MEM_LAT+2 cycles.
// Backpressure: requesters hold req until their one-cycle ack; the loser waits in IDLE.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          owner_q;
  logic          last_grant;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] c_rd_q;
  logic [DW-1:0] l_rd_q;
  logic          grant_vld;
  logic          grant_sel;
  logic          tie_sel;

`ifdef ARB_CORE_PRIO_EN
  assign tie_sel = 1'b0;
`else
  assign tie_sel = ~last_grant;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    case (state)
      IDLE: begin
        if (bus.c_req || bus.l_req) begin
          grant_vld = 1'b1;
          state_nxt = ACCESS;
          // A lone requester wins outright; ties go to the arbitration policy.
          grant_sel = (bus.c_req && bus.l_req) ? tie_sel : bus.l_req;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 4'd0;
      owner_q    <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wd_q       <= '0;
      c_rd_q     <= '0;
      l_rd_q     <= '0;
    end else if (grant_vld) begin
      owner_q    <= grant_sel;
      last_grant <= grant_sel;
      cnt        <= CNT_INIT;
      we_q       <= grant_sel ? bus.l_we  : bus.c_we;
      adr_q      <= grant_sel ? bus.l_adr : bus.c_adr;
      wd_q       <= grant_sel ? bus.l_wd  : bus.c_wd;
    end else if (state == ACCESS) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else if (!we_q) begin
        if (owner_q) l_rd_q <= bus.m_rd;
        else         c_rd_q <= bus.m_rd;
      end
    end
  end

  // Strobes decode from state so an asynchronous reset drops them immediately.
  assign bus.m_en  = (state == ACCESS);
  assign bus.m_we  = (state == ACCESS) && we_q;
  assign bus.m_adr = adr_q;
  assign bus.m_wd  = wd_q;
  assign bus.c_ack = (state == RESP) && !owner_q;
  assign bus.l_ack = (state == RESP) &&  owner_q;
  assign bus.c_rd  = c_rd_q;
  assign bus.l_rd  = l_rd_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT = 2; outputs sampled on the falling edge.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int order [3];
    int exp_order [3];
    logic got;
    logic both_seen;

    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_adr = 32'h0000_0010; bus.c_wd = 32'h0;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_adr = 32'h0000_0040; bus.l_wd = 32'h1234_5678;
    bus.m_rd  = 32'hDEAD_BEEF;

    // Reset held 3 cycles with both requests active.
    repeat (3) step();
    chk("rst_c_ack", {31'b0, bus.c_ack}, 32'd0);
    chk("rst_l_ack", {31'b0, bus.l_ack}, 32'd0);
    chk("rst_m_en",  {31'b0, bus.m_en},  32'd0);
    chk("rst_m_we",  {31'b0, bus.m_we},  32'd0);
    chk("rst_m_adr", bus.m_adr, 32'd0);
    chk("rst_m_wd",  bus.m_wd,  32'd0);
    chk("rst_c_rd",  bus.c_rd,  32'd0);
    chk("rst_l_rd",  bus.l_rd,  32'd0);
    chk("rst_owner", {31'b0, bus.owner}, 32'd0);
    rst = 1'b1;

    // Core read wins the first tie.
    step();
    chk("crd_m_en_1",  {31'b0, bus.m_en}, 32'd1);
    chk("crd_owner",   {31'b0, bus.owner}, 32'd0);
    chk("crd_m_adr",   bus.m_adr, 32'h0000_0010);
    chk("crd_m_we",    {31'b0, bus.m_we}, 32'd0);
    step();
    chk("crd_m_en_2",  {31'b0, bus.m_en}, 32'd1);
    chk("crd_noack",   {31'b0, bus.c_ack}, 32'd0);
    step();
    chk("crd_c_ack",   {31'b0, bus.c_ack}, 32'd1);
    chk("crd_l_ack",   {31'b0, bus.l_ack}, 32'd0);
    chk("crd_m_en_off",{31'b0, bus.m_en}, 32'd0);
    chk("crd_c_rd",    bus.c_rd, 32'hDEAD_BEEF);
    bus.c_req = 1'b0;
    step();
    chk("crd_ack_once",{31'b0, bus.c_ack}, 32'd0);
    chk("crd_rd_hold", bus.c_rd, 32'hDEAD_BEEF);

    // Loader write that lost the tie is served next.
    step();
    chk("lwr_owner",   {31'b0, bus.owner}, 32'd1);
    chk("lwr_m_we_1",  {31'b0, bus.m_we}, 32'd1);
    chk("lwr_m_wd",    bus.m_wd, 32'h1234_5678);
    chk("lwr_m_adr",   bus.m_adr, 32'h0000_0040);
    step();
    chk("lwr_m_we_2",  {31'b0, bus.m_we}, 32'd1);
    step();
    chk("lwr_l_ack",   {31'b0, bus.l_ack}, 32'd1);
    chk("lwr_c_ack",   {31'b0, bus.c_ack}, 32'd0);
    chk("lwr_m_we_off",{31'b0, bus.m_we}, 32'd0);
    chk("lwr_l_rd",    bus.l_rd, 32'd0);
    bus.l_req = 1'b0;
    step();
    chk("lwr_ack_once",{31'b0, bus.l_ack}, 32'd0);

    // Loader read; a core request raised and withdrawn meanwhile is ignored.
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.m_rd = 32'hCAFE_F00D;
    step();
    bus.c_req = 1'b1;
    step();
    bus.c_req = 1'b0;
    step();
    chk("lrd_l_ack",   {31'b0, bus.l_ack}, 32'd1);
    chk("lrd_l_rd",    bus.l_rd, 32'hCAFE_F00D);
    chk("lrd_c_rd",    bus.c_rd, 32'hDEAD_BEEF);
    bus.l_req = 1'b0;
    step();
    step();
    chk("wdraw_m_en",  {31'b0, bus.m_en}, 32'd0);
    step();
    chk("wdraw_c_ack", {31'b0, bus.c_ack}, 32'd0);
    chk("wdraw_m_en2", {31'b0, bus.m_en}, 32'd0);

    // Collision held over three transactions.
`ifdef ARB_CORE_PRIO_EN
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0;
`else
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0;
`endif
    bus.c_req = 1'b1; bus.c_we = 1'b0;
    bus.l_req = 1'b1; bus.l_we = 1'b0;
    bus.m_rd  = 32'h1111_2222;
    both_seen = 1'b0;
    for (int t = 0; t < 3; t++) begin
      got = 1'b0;
      order[t] = -1;
      for (int k = 0; k < 8 && !got; k++) begin
        step();
        if (bus.c_ack && bus.l_ack) both_seen = 1'b1;
        if (bus.c_ack) begin
          order[t] = 0; got = 1'b1;
        end else if (bus.l_ack) begin
          order[t] = 1; got = 1'b1;
        end
      end
      chk($sformatf("coll_ack_seen_%0d", t), {31'b0, got}, 32'd1);
      chk($sformatf("coll_order_%0d", t), order[t], exp_order[t]);
    end
    chk("coll_both_ack", {31'b0, both_seen}, 32'd0);
    bus.c_req = 1'b0; bus.l_req = 1'b0;
    step();

    // Core drops req during ACCESS; the ack still arrives.
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.m_rd = 32'h5A5A_5A5A;
    step();
    chk("drop_m_en",  {31'b0, bus.m_en}, 32'd1);
    chk("drop_owner", {31'b0, bus.owner}, 32'd0);
    bus.c_req = 1'b0;
    step();
    step();
    chk("drop_c_ack", {31'b0, bus.c_ack}, 32'd1);
    chk("drop_c_rd",  bus.c_rd, 32'h5A5A_5A5A);
    step();
    chk("drop_ack_once", {31'b0, bus.c_ack}, 32'd0);

    // Reset in the second ACCESS cycle aborts the core read.
    bus.c_req = 1'b1; bus.m_rd = 32'h0BAD_CAFE;
    step();
    chk("abort_m_en_pre", {31'b0, bus.m_en}, 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("abort_m_en",  {31'b0, bus.m_en}, 32'd0);
    chk("abort_c_ack", {31'b0, bus.c_ack}, 32'd0);
    chk("abort_c_rd",  bus.c_rd, 32'd0);
    step();
    chk("abort_c_ack2", {31'b0, bus.c_ack}, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("fresh_m_en", {31'b0, bus.m_en}, 32'd1);
    step();
    step();
    chk("fresh_c_ack", {31'b0, bus.c_ack}, 32'd1);
    chk("fresh_c_rd",  bus.c_rd, 32'h0BAD_CAFE);
    bus.c_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multi-cycle core (port C) and the program loader/debug port (port L).
- Serialises accesses, sequences the fixed-latency memory and returns a one-cycle ack to the winning requester.
- Sits between the core datapath memory interface and the memory macro; the core controller stalls on c_ack.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 2, memory access latency in cycles; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- c_req  in  1  core request; held until c_ack.
- c_we  in  1  core write enable (1 = write).
- c_adr  in  AW  core address.
- c_wd  in  DW  core write data.
- c_rd  out  DW  core read data; valid while c_ack = 1.
- c_ack  out  1  one-cycle completion pulse to core.
- l_req, l_we, l_adr, l_wd, l_rd, l_ack: same as the c_ signals, for the loader port.
- m_en  out  1  memory enable.
- m_we  out  1  memory write enable.
- m_adr  out  AW  memory address.
- m_wd  out  DW  memory write data.
- m_rd  in  DW  memory read data; valid in the last ACCESS cycle.
- owner  out  1  current/last grant (0 = core, 1 = loader).

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - c_ack, l_ack, m_en and m_we go to 0.
  - m_adr, m_wd, c_rd and l_rd go to 0.
  - last_grant goes to 1, so the core wins the first tie; owner goes to 0.
- FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester that is not last_grant (round-robin).
  - On grant: latch we/adr/wd into m_we/m_adr/m_wd, set owner and last_grant, load cnt = MEM_LAT-1, go to ACCESS.
- ACCESS:
  - m_en = 1; m_we/m_adr/m_wd are held stable.
  - Each cycle: if cnt = 0, go to RESP; else cnt decrements.
  - In the last ACCESS cycle (cnt = 0), a read captures m_rd into the winner's rd register.
  - A write leaves that rd register unchanged.
- RESP:
  - m_en = 0 and m_we = 0.
  - Pulse the winner's ack for exactly one cycle.
  - Go to IDLE unconditionally.
- Latency: with req first sampled in IDLE at edge T, ack is high during cycle T+MEM_LAT+1. Throughput is one access per MEM_LAT+2 cycles.
- Requester rules:
  - A requester holds req and its fields stable until ack.
  - The requester must drop req (or present a new request) in the cycle after ack.
  - The arbiter first samples req again in IDLE, so the ack cycle never causes a double grant.
- Boundary conditions:
  - Request withdrawn before grant: ignored, no ack.
  - Request dropped during ACCESS: the transaction completes and the ack is still pulsed.
  - Losing requester: waits; it is guaranteed the next grant (round-robin bounds wait to one transaction).
  - rd registers hold their value after ack until the next read completes for that port.
  - Reset mid-ACCESS: abort immediately, with no ack and m_en = 0. A memory write may be partially committed; this is acceptable.
  - c_ack and l_ack are never high in the same cycle.
  - MEM_LAT = 1: ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: ARB_CORE_PRIO_EN.
- Defined: fixed priority. The core wins every collision; last_grant is still updated but ignored. The loader can be starved while the core issues back-to-back requests.
- Not defined: round-robin exactly as in Behaviour.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with both req = 1 -> all outputs 0; after release, the core is granted first (owner = 0); m_en rises the cycle after the first sampling edge.
- Core read, MEM_LAT = 2: c_req = 1, c_adr = 0x0000_0010; memory returns 0xDEAD_BEEF -> m_en high 2 cycles with m_adr = 0x10; c_ack high exactly 1 cycle, 3 cycles after the sampling edge; c_rd = 0xDEAD_BEEF.
- Loader write: l_we = 1, l_adr = 0x40, l_wd = 0x1234_5678 -> m_we = 1, m_wd = 0x1234_5678 for 2 cycles; l_ack pulses once; l_rd is unchanged.
- Collision, round-robin: both req held for 3 transactions -> grant order C, L, C; acks alternate; never both high in one cycle.
- Collision with ARB_CORE_PRIO_EN defined: both req held for 3 transactions -> grant order C, C, C; l_ack never pulses.
- Abort: assert rst = 0 in the second ACCESS cycle of a core read -> m_en = 0 immediately; no c_ack; after release, a fresh c_req completes normally.
